// File: rtl/seq_mem_timer.sv
// =============================================================================
// Module   : seq_mem_timer
// Purpose  : Up/down address sequencer over a 2^ADDR_W x DATA_W word table,
//            with interval auto-stepping, wrap/saturate ends, direct load and a
//            registered read port. Optional write port: SEQ_MEM_WRITE_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module seq_mem_timer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int PERIOD = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              count_up_key,
    input  logic              count_down_key,
    input  logic              auto_en,
    input  logic              auto_dir,
    input  logic              wrap_en,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              tick,
    output logic              at_min,
    output logic              at_max,
    output logic              limit_hit
);

    localparam int                    c_DEPTH      = 1 << ADDR_W;
    localparam int                    c_TIMER_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [c_TIMER_W-1:0]  c_TIMER_LAST = c_TIMER_W'(PERIOD - 1);
    localparam logic [ADDR_W-1:0]     c_ADDR_MAX   = '1;

    logic [c_TIMER_W-1:0] r_timer;
    logic                 w_manual;
    logic                 w_expire;
    logic                 w_step;
    logic                 w_step_up;
    logic                 w_blocked;
    logic [ADDR_W-1:0]    w_next_addr;
    logic [DATA_W-1:0]    w_rd_data;

    // Power-on table pattern: word i holds i truncated/extended to DATA_W.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W && i < ADDR_W; i++) begin
            v[i] = a[i];
        end
        return v;
    endfunction

    assign at_min = (address == '0);
    assign at_max = (address == c_ADDR_MAX);

    assign w_manual    = count_up_key ^ count_down_key;
    assign w_expire    = auto_en && (r_timer == c_TIMER_LAST);
    // The registered tick drives the auto step one edge after it is seen.
    assign w_step      = !load && (w_manual || tick);
    assign w_step_up   = w_manual ? count_up_key : auto_dir;
    assign w_blocked   = w_step && !wrap_en && (w_step_up ? at_max : at_min);
    assign w_next_addr = w_step_up ? (address + ADDR_W'(1)) : (address - ADDR_W'(1));

`ifdef SEQ_MEM_WRITE_EN
    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_written;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Tracks which words override the power-on pattern; only this map is reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_written <= '0;
        end else if (wr_en) begin
            r_written[wr_addr] <= 1'b1;
        end
    end

    assign w_rd_data = r_written[address] ? r_mem[address] : init_word(address);
`else
    logic unused_wr_ports;
    assign unused_wr_ports = ^{wr_en, wr_addr, wr_data};
    assign w_rd_data       = init_word(address);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer    <= '0;
            tick       <= 1'b0;
            limit_hit  <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            address    <= '0;
        end else begin
            if (!auto_en || load || w_manual || w_expire) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TIMER_W'(1);
            end
            tick       <= w_expire && !load && !w_manual;
            limit_hit  <= w_blocked;
            data_valid <= 1'b1;
            data_out   <= w_rd_data;
            if (load) begin
                address <= load_addr;
            end else if (w_step && !w_blocked) begin
                address <= w_next_addr;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/seq_mem_timer.md
# seq_mem_timer

Parametrised successor to the counter-addressed sequence memory: an up/down address counter steps through a DATA_W-wide memory of 2^ADDR_W words, adding an auto-step interval timer, wrap/saturate selection, direct address load and a registered read port with valid flag. Sits between the key/control front end and downstream consumers of the sequenced data word. An optional write port is compiled in by macro.

## Interface
- ADDR_W, 4, address width; depth = 2^ADDR_W words (ADDR_W >= 1)
- DATA_W, 8, data word width
- PERIOD, 16, auto-step interval in clk cycles (PERIOD >= 1)
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- count_up_key  in  1  manual step up request (per cycle)
- count_down_key  in  1  manual step down request (per cycle)
- auto_en  in  1  enable interval timer auto-stepping
- auto_dir  in  1  auto-step direction, 1 = up, 0 = down
- wrap_en  in  1  1 = modular wrap at ends, 0 = saturate
- load  in  1  load address from load_addr
- load_addr  in  ADDR_W  address to load
- wr_en  in  1  memory write strobe (macro-dependent)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- address  out  ADDR_W  current address register
- data_out  out  DATA_W  registered memory read of address
- data_valid  out  1  data_out holds a valid read
- tick  out  1  one-cycle pulse when interval timer expires
- at_min  out  1  address == 0 (combinational from address)
- at_max  out  1  address == 2^ADDR_W-1 (combinational)
- limit_hit  out  1  one-cycle pulse: saturated step was blocked

## Operation
- Memory initial content: mem[i] = i mod 2^DATA_W; memory is not cleared by reset.
- Per-cycle step source priority: load > manual > auto tick.
- Manual step: exactly one of count_up_key/count_down_key high. Both high or both low: no manual step.
- Timer: counter 0..PERIOD-1 increments while auto_en=1; at PERIOD-1 it asserts tick and returns to 0. Cleared to 0 when auto_en=0, on load, or on any manual step (interval restarts).
- A tick in a cycle with load or manual step is suppressed (timer cleared instead).
- Step arithmetic in ADDR_W bits. wrap_en=1: max+1 -> 0, 0-1 -> max. wrap_en=0: up at max / down at 0 leaves address unchanged and pulses limit_hit.
- load: address <= load_addr next cycle, regardless of keys and wrap_en.
- Read: data_out <= mem[address] every cycle.
- Write (macro on): wr_en=1 writes mem[wr_addr] <= wr_data; read-before-write on same-cycle collision.

## Timing
- Reset values: address 0, data_out 0, data_valid 0, tick 0, limit_hit 0, at_min 1, at_max 0, timer 0.
- address changes on the edge after the step condition is sampled (1-cycle latency).
- data_out valid for address of previous cycle: address change at edge t -> matching data_out at edge t+1.
- data_valid rises on the first edge after reset_n deasserts, then stays 1 until reset.
- With auto_en held and no other activity: tick every PERIOD cycles, first tick PERIOD cycles after auto_en rises; address steps the edge after tick. PERIOD=1: tick every cycle.
- Write at edge t to address == current address: data_out shows old value at t, new value at t+1.
- reset_n assertion mid-operation: all registers return to reset values immediately (asynchronous); timer restarts from 0 on release.

## Configuration
- SEQ_MEM_WRITE_EN defined: wr_en/wr_addr/wr_data write the memory as above.
- Not defined: memory is read-only with initial content; wr_* ports remain in the interface and are ignored.

## Test plan
- Reset then release, hold count_up_key 5 cycles (ADDR_W=4) -> address 1..5, data_out trails by one cycle (0..4 then 5), data_valid=1 from first edge.
- wrap_en=1, load 15, one up step -> address 0, at_min=1; wrap_en=0, load 15, up -> address stays 15, limit_hit pulses once, at_max=1.
- auto_en=1, auto_dir=0, PERIOD=4, start at 3 -> tick every 4 cycles, address 2,1,0,15 (wrap) with ticks; manual key mid-interval restarts the 4-cycle count.
- Both keys high with load=1, load_addr=9 -> address 9; both keys high alone -> address unchanged.
- SEQ_MEM_WRITE_EN: write 0xA5 to current address 6 -> data_out 0x06 next edge, 0xA5 the edge after; macro off -> stays 0x06.
- Assert reset_n low mid auto-stepping at address 7 -> address 0, data_out 0, data_valid 0, tick 0 immediately without a clock edge.
